vga_fb_display: RTL and testbench
=================================

Name: vga_fb_display

Overview:
- Pixel stage directly downstream of the VGA timing generator. Consumes its hs/vs/en/x/y and drives the VGA connector pins with colour and sync.
- Holds a double-buffered, down-scaled framebuffer (160x120, 12-bit RGB, 4x4 pixel replication to 640x480) with a host write port.
- Buffer swap is synchronised to the start of vertical sync, so writes never tear the displayed frame.

Parameters:
- FB_W, 160, framebuffer width in stored pixels
- FB_H, 120, framebuffer height in stored pixels
- SHIFT, 2, log2 of the scale factor; screen coordinate >> SHIFT gives the framebuffer coordinate
- CW, 12, colour width (4:4:4 RGB)
- AW, 15, framebuffer address width (ceil log2 of FB_W*FB_H)
- BG_COLOR, 12'h000, colour for active pixels outside the framebuffer area

Ports:
- clk  in  1  system clock, 100 MHz (same clock as the timing generator)
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- hs_in  in  1  horizontal sync from the timing generator, active-low
- vs_in  in  1  vertical sync from the timing generator, active-low
- en_in  in  1  active-video flag
- x_in  in  16  pixel column, 0..639 when en_in=1
- y_in  in  16  pixel row, 0..479 when en_in=1
- wr_en  in  1  host write strobe, one write per cycle
- wr_addr  in  AW  host write address, y*FB_W+x
- wr_data  in  CW  host write colour
- swap_req  in  1  request a front/back buffer swap
- swap_busy  out  1  swap pending, waiting for vsync
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- front  out  1  index of the bank currently displayed
- vga_hs  out  1  sync to connector, active-low
- vga_vs  out  1  sync to connector, active-low
- vga_rgb  out  CW  colour to connector

Behaviour:
- Inputs are sampled on every clk edge, with no clock enable. Timing-generator outputs simply repeat across its 4-cycle pixel period.
- Stage 1 (registered):
  - fx = x_in>>SHIFT, fy = y_in>>SHIFT
  - in_range = en_in & fx<FB_W & fy<FB_H
  - rd_addr = fy*FB_W + fx, computed as (fy<<7)+(fy<<5)+fx for the defaults; generic multiply by a constant is allowed
  - hs, vs, en, in_range delayed one cycle
- Stage 2 (registered): synchronous read of bank[front] at rd_addr. Output registers:
  - vga_rgb = en_d2 ? (in_range_d2 ? mem_q : BG_COLOR) : 0
  - vga_hs = hs_d2, vga_vs = vs_d2
- Latency: all outputs lag the inputs by exactly 2 clk cycles, and sync and colour stay mutually aligned.
- Memory: two banks of FB_W*FB_H x CW, inferable as BRAM. Contents are not reset.
- Writes:
  - A write with wr_en=1 goes to bank[~front], using the registered front value of that cycle.
  - wr_addr >= FB_W*FB_H: the write is dropped silently.
  - Writes never touch the displayed bank, so there is no read/write collision on the display path.
- Swap FSM, states IDLE and PENDING:
  - IDLE -> PENDING when swap_req=1. swap_busy=1 in PENDING.
  - vsync-start event: vs_in=0 while its 1-cycle delayed copy is 1.
  - On a vsync-start event, if in PENDING or swap_req=1 that cycle: front <= ~front, swap_ack=1 for one cycle, go to IDLE.
  - swap_req while PENDING has no extra effect; a second swap needs a new request after swap_ack.
  - swap_req in the same cycle as swap_ack starts a new PENDING.
- Reset (rst=0, asynchronous):
  - vga_rgb=0, vga_hs=1, vga_vs=1, all pipeline en/in_range=0, sync delay registers=1
  - front=0, state IDLE, swap_busy=0, swap_ack=0
  - A swap pending when reset asserts is discarded. A mid-frame reset resumes cleanly on the next input sample after release.

Test Plan:
- Reset release with en_in=1, x_in=0, y_in=0, bank0[0]=12'hF00 preloaded through a swap -> vga_rgb=0 and syncs=1 during reset; vga_rgb=12'hF00 exactly 2 cycles after first sample.
- Write 12'h0A5 at addr 161, then swap at vsync; drive x_in=4..7, y_in=4..7 -> all 16 screen pixels read 12'h0A5 with 2-cycle latency; x_in=8,y_in=4 reads addr 162.
- en_in=0 with x_in=y_in=0 and bank data nonzero -> vga_rgb=0; hs_in/vs_in pulses reappear on vga_hs/vga_vs delayed 2 cycles, same width.
- swap_req pulse mid-frame -> swap_busy=1, front unchanged until vs_in falls; swap_ack single pulse on that edge, front toggles; writes issued before the edge landed in the now-displayed bank.
- swap_req coincident with the vs_in falling edge -> immediate swap, swap_busy never asserts; wr_addr=19200 write -> no bank location changes.
- rst asserted while PENDING mid-line -> outputs go to reset values asynchronously; after release swap_busy=0, front=0, no swap_ack at the next vsync.

Source files
------------

// File: rtl/vga_fb_display.sv
// Pixel stage behind the VGA timing generator: a double-buffered, down-scaled framebuffer
// replicated onto the 640x480 raster, with front/back swaps locked to the start of vsync.
module vga_fb_display #(
  parameter int             FB_W     = 160,
  parameter int             FB_H     = 120,
  parameter int             SHIFT    = 2,
  parameter int             CW       = 12,
  parameter int             AW       = 15,
  parameter logic [CW-1:0]  BG_COLOR = 12'h000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          en_in,
  input  logic [15:0]   x_in,
  input  logic [15:0]   y_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          swap_req,
  output logic          swap_busy,
  output logic          swap_ack,
  output logic          front,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic [CW-1:0] vga_rgb
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int FXW   = 16 - SHIFT;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swapState_e;

  logic [FXW-1:0] fx;
  logic [FXW-1:0] fy;
  logic           inRange_d;
  logic [AW-1:0]  rdAddr_d;
  logic           unusedLowBits;

  logic           hs1_q, vs1_q, en1_q, inRange1_q;
  logic [AW-1:0]  rdAddr_q;
  logic           hs2_q, vs2_q, en2_q, inRange2_q;
  logic [CW-1:0]  pix_q;

  swapState_e     state_q;
  logic           front_q;
  logic           swapAck_q;
  logic           swapBusy_q;
  logic           vsyncStart;
  logic           wrOk;

  logic [CW-1:0]  bank0 [0:DEPTH-1];
  logic [CW-1:0]  bank1 [0:DEPTH-1];

  // The sub-pixel bits only select the replica within a 4x4 block, so they are discarded.
  assign fx            = x_in[15:SHIFT];
  assign fy            = y_in[15:SHIFT];
  assign unusedLowBits = ^{x_in[SHIFT-1:0], y_in[SHIFT-1:0]};
  assign inRange_d     = en_in && (int'(fx) < FB_W) && (int'(fy) < FB_H);
  assign rdAddr_d      = AW'(int'(fy) * FB_W + int'(fx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      en1_q      <= 1'b0;
      inRange1_q <= 1'b0;
      rdAddr_q   <= '0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      en2_q      <= 1'b0;
      inRange2_q <= 1'b0;
    end else begin
      hs1_q      <= hs_in;
      vs1_q      <= vs_in;
      en1_q      <= en_in;
      inRange1_q <= inRange_d;
      rdAddr_q   <= rdAddr_d;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      en2_q      <= en1_q;
      inRange2_q <= inRange1_q;
    end
  end

  // Host writes always land in the hidden bank; out-of-range addresses are dropped.
  assign wrOk = wr_en && (int'(wr_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wrOk && front_q) begin
      bank0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wrOk && !front_q) begin
      bank1[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (front_q) begin
      pix_q <= bank1[rdAddr_q];
    end else begin
      pix_q <= bank0[rdAddr_q];
    end
  end

  assign vsyncStart = !vs_in && vs1_q;

  // A request arriving on the vsync-start cycle itself swaps at once without going busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      swapAck_q  <= 1'b0;
      swapBusy_q <= 1'b0;
    end else begin
      swapAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vsyncStart && swap_req) begin
            front_q   <= ~front_q;
            swapAck_q <= 1'b1;
          end else if (swap_req) begin
            state_q    <= PENDING;
            swapBusy_q <= 1'b1;
          end
        end
        PENDING: begin
          if (vsyncStart) begin
            front_q    <= ~front_q;
            swapAck_q  <= 1'b1;
            state_q    <= IDLE;
            swapBusy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          swapBusy_q <= 1'b0;
        end
      endcase
    end
  end

  assign swap_busy = swapBusy_q;
  assign swap_ack  = swapAck_q;
  assign front     = front_q;
  assign vga_hs    = hs2_q;
  assign vga_vs    = vs2_q;
  assign vga_rgb   = en2_q ? (inRange2_q ? pix_q : BG_COLOR) : '0;

endmodule

// File: tb/tb_vga_fb_display.sv
// Directed bench for vga_fb_display: reset, scaling, blanking/sync delay, swap handshake,
// dropped out-of-range writes and reset during a pending swap.
module tb_vga_fb_display;

  localparam int CW = 12;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hs_in = 1'b1;
  logic          vs_in = 1'b1;
  logic          en_in = 1'b0;
  logic [15:0]   x_in = '0;
  logic [15:0]   y_in = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic          swap_req = 1'b0;
  logic          swap_busy, swap_ack, front, vga_hs, vga_vs;
  logic [CW-1:0] vga_rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_display dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .en_in(en_in),
    .x_in(x_in), .y_in(y_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_busy(swap_busy), .swap_ack(swap_ack), .front(front),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb)
  );

  task automatic doWrite(input logic [AW-1:0] a, input logic [CW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Drives one pixel coordinate and returns the colour seen two cycles later.
  task automatic showPixel(input int x, input int y, input logic en, output logic [CW-1:0] rgb);
    @(negedge clk);
    en_in = en; x_in = 16'(x); y_in = 16'(y);
    @(negedge clk);
    @(negedge clk);
    rgb = vga_rgb;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    en_in = 1'b1; x_in = '0; y_in = '0; hs_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected %h", vga_rgb, 12'h000); end
    checks++; if (vga_hs !== 1'b1) begin errors++; $display("[TB] FAIL reset_hs: got %b expected 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin errors++; $display("[TB] FAIL reset_vs: got %b expected 1", vga_vs); end
    checks++; if (front !== 1'b0) begin errors++; $display("[TB] FAIL reset_front: got %b expected 0", front); end
    checks++; if (swap_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", swap_busy); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", swap_ack); end
    hs_in = 1'b1; en_in = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_swap_pending;
    logic [CW-1:0] rgb;
    doWrite(15'd0, 12'h0F0);
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0;
    checks++; if (swap_busy !== 1'b1) begin errors++; $display("[TB] FAIL pend_busy: got %b expected 1", swap_busy); end
    checks++; if (front !== 1'b0) begin errors++; $display("[TB] FAIL pend_front: got %b expected 0", front); end
    doWrite(15'd160, 12'h00F);
    repeat (3) @(negedge clk);
    checks++; if (swap_busy !== 1'b1) begin errors++; $display("[TB] FAIL pend_busy_hold: got %b expected 1", swap_busy); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL pend_no_ack: got %b expected 0", swap_ack); end
    vs_in = 1'b0;
    @(negedge clk);
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("[TB] FAIL pend_ack: got %b expected 1", swap_ack); end
    checks++; if (front !== 1'b1) begin errors++; $display("[TB] FAIL pend_front_swap: got %b expected 1", front); end
    checks++; if (swap_busy !== 1'b0) begin errors++; $display("[TB] FAIL pend_busy_clr: got %b expected 0", swap_busy); end
    @(negedge clk);
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL pend_ack_pulse: got %b expected 0", swap_ack); end
    vs_in = 1'b1;
    showPixel(0, 0, 1'b1, rgb);
    checks++; if (rgb !== 12'h0F0) begin errors++; $display("[TB] FAIL pend_pix00: got %h expected %h", rgb, 12'h0F0); end
    showPixel(0, 4, 1'b1, rgb);
    checks++; if (rgb !== 12'h00F) begin errors++; $display("[TB] FAIL pend_pix04: got %h expected %h", rgb, 12'h00F); end
    en_in = 1'b0;
    doWrite(15'd0, 12'hF00);
  endtask

  task automatic test_reset_release;
    @(negedge clk);
    en_in = 1'b1; x_in = '0; y_in = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("[TB] FAIL rr_async_rgb: got %h expected %h", vga_rgb, 12'h000); end
    checks++; if (front !== 1'b0) begin errors++; $display("[TB] FAIL rr_front: got %b expected 0", front); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("[TB] FAIL rr_lat1: got %h expected %h", vga_rgb, 12'h000); end
    @(negedge clk);
    checks++; if (vga_rgb !== 12'hF00) begin errors++; $display("[TB] FAIL rr_lat2: got %h expected %h", vga_rgb, 12'hF00); end
    en_in = 1'b0;
  endtask

  task automatic test_scaling;
    logic [CW-1:0] rgb;
    doWrite(15'd161, 12'h0A5);
    doWrite(15'd162, 12'h5A0);
    doWrite(15'd19199, 12'h123);
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0; vs_in = 1'b0;
    @(negedge clk);
    @(negedge clk); vs_in = 1'b1;
    checks++; if (front !== 1'b1) begin errors++; $display("[TB] FAIL scale_front: got %b expected 1", front); end
    for (int y = 4; y < 8; y++) begin
      for (int x = 4; x < 8; x++) begin
        showPixel(x, y, 1'b1, rgb);
        checks++; if (rgb !== 12'h0A5) begin errors++; $display("[TB] FAIL scale_%0d_%0d: got %h expected %h", x, y, rgb, 12'h0A5); end
      end
    end
    showPixel(8, 4, 1'b1, rgb);
    checks++; if (rgb !== 12'h5A0) begin errors++; $display("[TB] FAIL scale_8_4: got %h expected %h", rgb, 12'h5A0); end
    showPixel(3, 4, 1'b1, rgb);
    checks++; if (rgb !== 12'h00F) begin errors++; $display("[TB] FAIL scale_3_4: got %h expected %h", rgb, 12'h00F); end
    showPixel(636, 476, 1'b1, rgb);
    checks++; if (rgb !== 12'h123) begin errors++; $display("[TB] FAIL scale_last: got %h expected %h", rgb, 12'h123); end
    showPixel(639, 479, 1'b1, rgb);
    checks++; if (rgb !== 12'h123) begin errors++; $display("[TB] FAIL scale_corner: got %h expected %h", rgb, 12'h123); end
    showPixel(4, 480, 1'b1, rgb);
    checks++; if (rgb !== 12'h000) begin errors++; $display("[TB] FAIL scale_outside: got %h expected %h", rgb, 12'h000); end
    en_in = 1'b0;
  endtask

  task automatic test_blank_sync;
    logic [CW-1:0] rgb;
    logic hsPat [0:11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic vsPat [0:11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    showPixel(0, 0, 1'b0, rgb);
    checks++; if (rgb !== 12'h000) begin errors++; $display("[TB] FAIL blank_rgb: got %h expected %h", rgb, 12'h000); end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (vga_hs !== hsPat[i-2]) begin errors++; $display("[TB] FAIL sync_hs_%0d: got %b expected %b", i, vga_hs, hsPat[i-2]); end
        checks++; if (vga_vs !== vsPat[i-2]) begin errors++; $display("[TB] FAIL sync_vs_%0d: got %b expected %b", i, vga_vs, vsPat[i-2]); end
      end
      hs_in = (i < 12) ? hsPat[i] : 1'b1;
      vs_in = (i < 12) ? vsPat[i] : 1'b1;
    end
    checks++; if (front !== 1'b1) begin errors++; $display("[TB] FAIL sync_front_kept: got %b expected 1", front); end
  endtask

  task automatic test_back_to_back;
    logic [CW-1:0] rgb;
    @(negedge clk);
    swap_req = 1'b1; vs_in = 1'b0;
    @(negedge clk);
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("[TB] FAIL coin_ack: got %b expected 1", swap_ack); end
    checks++; if (swap_busy !== 1'b0) begin errors++; $display("[TB] FAIL coin_busy: got %b expected 0", swap_busy); end
    checks++; if (front !== 1'b0) begin errors++; $display("[TB] FAIL coin_front: got %b expected 0", front); end
    @(negedge clk);
    checks++; if (swap_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", swap_busy); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack_pulse: got %b expected 0", swap_ack); end
    swap_req = 1'b0; vs_in = 1'b1;
    doWrite(15'd19200, 12'hFFF);
    @(negedge clk); vs_in = 1'b0;
    @(negedge clk);
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack: got %b expected 1", swap_ack); end
    checks++; if (front !== 1'b1) begin errors++; $display("[TB] FAIL b2b_front: got %b expected 1", front); end
    vs_in = 1'b1;
    showPixel(0, 0, 1'b1, rgb);
    checks++; if (rgb !== 12'h0F0) begin errors++; $display("[TB] FAIL oob_pix00: got %h expected %h", rgb, 12'h0F0); end
    showPixel(4, 4, 1'b1, rgb);
    checks++; if (rgb !== 12'h0A5) begin errors++; $display("[TB] FAIL oob_pix44: got %h expected %h", rgb, 12'h0A5); end
    showPixel(636, 476, 1'b1, rgb);
    checks++; if (rgb !== 12'h123) begin errors++; $display("[TB] FAIL oob_last: got %h expected %h", rgb, 12'h123); end
  endtask

  task automatic test_reset_pending;
    @(negedge clk);
    en_in = 1'b1; x_in = '0; y_in = '0; swap_req = 1'b1; hs_in = 1'b0;
    @(negedge clk); swap_req = 1'b0;
    @(negedge clk);
    checks++; if (swap_busy !== 1'b1) begin errors++; $display("[TB] FAIL rp_busy: got %b expected 1", swap_busy); end
    checks++; if (vga_hs !== 1'b0) begin errors++; $display("[TB] FAIL rp_hs_pre: got %b expected 0", vga_hs); end
    checks++; if (vga_rgb !== 12'h0F0) begin errors++; $display("[TB] FAIL rp_rgb_pre: got %h expected %h", vga_rgb, 12'h0F0); end
    #3 rst = 1'b0;
    #1;
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("[TB] FAIL rp_rgb: got %h expected %h", vga_rgb, 12'h000); end
    checks++; if (vga_hs !== 1'b1) begin errors++; $display("[TB] FAIL rp_hs: got %b expected 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin errors++; $display("[TB] FAIL rp_vs: got %b expected 1", vga_vs); end
    checks++; if (swap_busy !== 1'b0) begin errors++; $display("[TB] FAIL rp_busy_rst: got %b expected 0", swap_busy); end
    checks++; if (front !== 1'b0) begin errors++; $display("[TB] FAIL rp_front: got %b expected 0", front); end
    @(negedge clk);
    hs_in = 1'b1; rst = 1'b1;
    @(negedge clk); vs_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL rp_no_ack_%0d: got %b expected 0", i, swap_ack); end
      if (i == 1) vs_in = 1'b1;
    end
    checks++; if (front !== 1'b0) begin errors++; $display("[TB] FAIL rp_front_after: got %b expected 0", front); end
    checks++; if (swap_busy !== 1'b0) begin errors++; $display("[TB] FAIL rp_busy_after: got %b expected 0", swap_busy); end
    en_in = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_swap_pending();
    test_reset_release();
    test_scaling();
    test_blank_sync();
    test_back_to_back();
    test_reset_pending();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
